pc_next_ctrl: RTL
=================

PC_NEXT_CTRL -- requirements
Module: pc_next_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset_in.
REQ-002 Parameter SHALL be RESET_VECTOR, default 32'h0000_0000: the first fetch address after reset.
REQ-003 Ports, listed as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- reset_in  in  1  synchronous active-high reset.
- pc_in  in  32  current PC, taken from the PC register output.
- stall_in  in  1  hazard stall: hold the PC.
- imem_ready_in  in  1  instruction memory accepted the fetch at pc_in.
- branch_taken_in  in  1  resolved taken branch.
- branch_target_in  in  32  branch target.
- jump_in  in  1  jump or jr resolved.
- jump_target_in  in  32  jump target.
- pc_next_out  out  32  next PC, drives the PC register address input.
- pc_write_out  out  1  drives the PC register write enable.
- redirect_pending_out  out  1  a redirect is latched and not yet applied.
- misalign_err_out  out  1  sticky flag: a target had bits [1:0] != 0.
- fetch_count_out  out  32  count of accepted fetches.

Function
REQ-004 The FSM SHALL have four states: BOOT, RUN, WAIT_MEM, HOLD_REDIR.
REQ-005 BOOT SHALL:
- drive pc_next_out = RESET_VECTOR and pc_write_out = 1 for exactly one cycle;
- then go to RUN.
REQ-006 In RUN, target selection SHALL follow this priority: jump_in > branch_taken_in > sequential (pc_in + 4).
REQ-007 In RUN, when stall_in=0 and imem_ready_in=1:
- pc_write_out = 1 and pc_next_out = the selected target;
- the PC advances at the same posedge.
REQ-008 In RUN with stall_in=0 and imem_ready_in=0:
- With no redirect: pc_write_out = 0 and the FSM goes to WAIT_MEM.
- With a redirect: the target is latched, redirect_pending_out rises, and the FSM goes to HOLD_REDIR.
REQ-009 In RUN with stall_in=1:
- pc_write_out = 0.
- A redirect asserted during the stall SHALL be latched, and the FSM goes to HOLD_REDIR.
REQ-010 WAIT_MEM SHALL:
- hold pc_write_out = 0 until imem_ready_in=1;
- in that cycle, behave as RUN, including redirect selection and stall.
REQ-011 HOLD_REDIR SHALL:
- ignore new jump_in and branch_taken_in (the first latched target wins);
- when stall_in=0 and imem_ready_in=1, drive pc_next_out = the latched target with pc_write_out = 1;
- clear redirect_pending_out and return to RUN.
REQ-012 pc_next_out and pc_write_out SHALL be combinational from the current state, the latched target and the inputs, giving zero added latency.
REQ-013 The sequential increment SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
REQ-014 Any selected redirect target with [1:0] != 0 SHALL:
- set misalign_err_out, which stays set until reset;
- be applied with bits [1:0] forced to 2'b00.
REQ-015 fetch_count_out SHALL increment by 1 on every cycle with pc_write_out=1, including BOOT, and wrap from 32'hFFFF_FFFF to 0.
REQ-016 When stall_in and imem_ready_in are both 1, stall SHALL win and no write occurs.

Reset
REQ-017 While reset_in=1, the outputs SHALL be:
- pc_write_out = 0, pc_next_out = RESET_VECTOR;
- redirect_pending_out = 0, misalign_err_out = 0, fetch_count_out = 0.
REQ-018 reset_in sampled high SHALL:
- move the FSM to BOOT;
- discard any latched target, including mid-WAIT_MEM or mid-HOLD_REDIR;
- take effect at the next posedge.

Structure
REQ-019 The following SHALL live in shared package cpu_pkg: the state encoding typedef, PC_INCR = 4, and the RESET_VECTOR default.
REQ-020 The block SHALL be a single module with no sub-modules; the PC register itself stays external.

Verification
REQ-021 Reset release, no stall, imem always ready -> BOOT writes 0, then pc_next_out is 4, 8, 12; fetch_count_out is 1, 2, 3, 4.
REQ-022 jump_in=1 (target 32'h100) and branch_taken_in=1 (target 32'h200) in the same cycle -> pc_next_out = 32'h100 with write=1.
REQ-023 stall_in=1 for 3 cycles, branch to 32'h40 in stall cycle 1, then jump to 32'h80 in cycle 2 -> no writes during the stall; after release, the PC is written to 32'h40 once and redirect_pending_out falls.
REQ-024 imem_ready_in=0 for 2 cycles from pc_in = 32'hFFFF_FFFC -> write=0 in both cycles, then write of 32'h0; fetch_count_out rises by 1.
REQ-025 Jump target 32'h103 -> applied as 32'h100 and misalign_err_out=1 held; reset_in mid-HOLD_REDIR -> all outputs at their reset values, then BOOT writes RESET_VECTOR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-controller state encoding, PC increment,
// default reset vector and small address helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_WAIT_MEM   = 2'd2,
        ST_HOLD_REDIR = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_INCR              = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when a byte address is not on a word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: picks the next fetch address (boot vector, sequential,
// branch or jump), holds it across stalls and memory back-pressure, and keeps
// a pending redirect until the fetch path can accept it. The PC register
// itself is external; this block drives its address and write enable.
module pc_next_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    input  logic        imem_ready_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        jump_in,
    input  logic [31:0] jump_target_in,
    output logic [31:0] pc_next_out,
    output logic        pc_write_out,
    output logic        redirect_pending_out,
    output logic        misalign_err_out,
    output logic [31:0] fetch_count_out
);

    pc_state_e   state_q, state_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic        redirect_pending_q, redirect_pending_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        go_s;
    logic        redir_s;
    logic [31:0] raw_tgt_s;
    logic [31:0] redir_tgt_s;
    logic [31:0] seq_pc_s;
    logic        pc_write_s;
    logic [31:0] pc_next_s;

    // Candidate targets: jump outranks branch; redirects are word-aligned.
    always_comb begin
        go_s        = (~stall_in) & imem_ready_in;
        redir_s     = jump_in | branch_taken_in;
        raw_tgt_s   = jump_in ? jump_target_in : branch_target_in;
        redir_tgt_s = word_align(raw_tgt_s);
        seq_pc_s    = pc_in + PC_INCR;
    end

    // State register and latched redirect / sticky error / fetch counter.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q            <= ST_BOOT;
            redir_tgt_q        <= 32'h0000_0000;
            redirect_pending_q <= 1'b0;
            misalign_q         <= 1'b0;
            fetch_count_q      <= 32'h0000_0000;
        end else begin
            state_q            <= state_d;
            redir_tgt_q        <= redir_tgt_d;
            redirect_pending_q <= redirect_pending_d;
            misalign_q         <= misalign_d;
            fetch_count_q      <= fetch_count_d;
        end
    end

    // Next-state logic: latch a redirect whenever it cannot be applied now.
    always_comb begin
        state_d            = state_q;
        redir_tgt_d        = redir_tgt_q;
        redirect_pending_d = redirect_pending_q;
        misalign_d         = misalign_q;
        fetch_count_d      = pc_write_s ? (fetch_count_q + 32'd1) : fetch_count_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_WAIT_MEM: begin
                if (redir_s && is_misaligned(raw_tgt_s)) begin
                    misalign_d = 1'b1;
                end else begin
                    misalign_d = misalign_q;
                end
                if (go_s) begin
                    state_d = ST_RUN;
                end else if (redir_s) begin
                    state_d            = ST_HOLD_REDIR;
                    redir_tgt_d        = redir_tgt_s;
                    redirect_pending_d = 1'b1;
                end else if (!stall_in) begin
                    state_d = ST_WAIT_MEM;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD_REDIR: begin
                if (go_s) begin
                    state_d            = ST_RUN;
                    redirect_pending_d = 1'b0;
                end else begin
                    state_d = ST_HOLD_REDIR;
                end
            end
            default: begin
                state_d            = ST_BOOT;
                redirect_pending_d = 1'b0;
            end
        endcase
    end

    // Output logic: zero-latency address and write enable for the PC register.
    always_comb begin
        pc_write_s = 1'b0;
        pc_next_s  = RESET_VECTOR;
        if (reset_in) begin
            pc_write_s = 1'b0;
            pc_next_s  = RESET_VECTOR;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    pc_write_s = 1'b1;
                    pc_next_s  = RESET_VECTOR;
                end
                ST_RUN, ST_WAIT_MEM: begin
                    pc_write_s = go_s;
                    pc_next_s  = redir_s ? redir_tgt_s : seq_pc_s;
                end
                ST_HOLD_REDIR: begin
                    pc_write_s = go_s;
                    pc_next_s  = redir_tgt_q;
                end
                default: begin
                    pc_write_s = 1'b0;
                    pc_next_s  = RESET_VECTOR;
                end
            endcase
        end
    end

    // Output drive; status outputs read as cleared for the whole reset cycle.
    always_comb begin
        pc_next_out          = pc_next_s;
        pc_write_out         = pc_write_s;
        redirect_pending_out = redirect_pending_q & ~reset_in;
        misalign_err_out     = misalign_q & ~reset_in;
        fetch_count_out      = fetch_count_q & {32{~reset_in}};
    end

endmodule
